vga_fb_disp: RTL and testbench

- Parametrised successor to the fixed BMP-ROM picture display.
- Generates VGA timing internally and reads pixels from a writable on-chip framebuffer with integer pixel up-scaling.
- Can also show built-in test patterns, selected per frame.
- Sits between the system (framebuffer write port, mode control) and the VGA DAC pins.

---
 rtl/vga_pkg.sv | 12 +
 rtl/vga_fb_disp_if.sv | 9 +
 rtl/vga_timing.sv | 35 +++
 rtl/vga_fb_disp.sv | 95 +++++++++
 tb/tb_vga_fb_disp.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared mode encodings, colour-bar palette and colour-field expansion for vga_fb_disp
package vga_pkg;
  typedef enum logic [1:0] {MODE_FB, MODE_BARS, MODE_CHECK, MODE_BLACK} mode_t;
  localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  function automatic logic [7:0] expand(input logic [7:0] f, input int w);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < 8; i += w) o = o | ((f << (8 - w)) >> i);
    return o;
  endfunction
endpackage

// File: rtl/vga_fb_disp_if.sv
// vga_fb_disp_if: system-side bus (framebuffer write port wr_en/wr_addr/wr_data, display mode)
interface vga_fb_disp_if #(parameter int AW = 17, parameter int PIX_BITS = 12);
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [PIX_BITS-1:0] wr_data;
  logic [1:0] mode;
  modport master (output wr_en, wr_addr, wr_data, mode);
  modport slave (input wr_en, wr_addr, wr_data, mode);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: h/v counters and stage-0 decode; in clk/rst, out h_cnt/v_cnt/active/hsync/vsync/sof
module vga_timing #(
  parameter int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
  parameter int V_ACTIVE = 480, V_FP = 10, V_SYNC = 2, V_BP = 33,
  parameter int SYNC_POL = 0,
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(H_TOT),
  localparam int VW = $clog2(V_TOT)
) (
  input  logic clk,
  input  logic rst,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic sof
);
  localparam logic SP = SYNC_POL[0];
  always_ff @(posedge clk)
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_cnt == HW'(H_TOT - 1) ? '0 : h_cnt + 1'b1;
      if (h_cnt == HW'(H_TOT - 1)) v_cnt <= v_cnt == VW'(V_TOT - 1) ? '0 : v_cnt + 1'b1;
    end
  always_comb begin
    active = h_cnt < HW'(H_ACTIVE) && v_cnt < VW'(V_ACTIVE);
    hsync = (h_cnt >= HW'(H_ACTIVE + H_FP) && h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)) ? SP : !SP;
    vsync = (v_cnt >= VW'(V_ACTIVE + V_FP) && v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)) ? SP : !SP;
    sof = h_cnt == '0 && v_cnt == '0;
  end
endmodule

// File: rtl/vga_fb_disp.sv
// vga_fb_disp: scaled framebuffer/test-pattern VGA display; in clk/rst/sys bus, out frame_start + VGA_* pins
module vga_fb_disp import vga_pkg::*; #(
  parameter int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
  parameter int V_ACTIVE = 480, V_FP = 10, V_SYNC = 2, V_BP = 33,
  parameter int SYNC_POL = 0,
  parameter int SCALE_SH = 1,
  parameter int PIX_BITS = 12
) (
  input  logic clk,
  input  logic rst,
  vga_fb_disp_if.slave sys,
  output logic frame_start,
  output logic VGA_CLK,
  output logic VGA_HSYNC,
  output logic VGA_VSYNC,
  output logic VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int FB_W = H_ACTIVE >> SCALE_SH;
  localparam int FB_N = FB_W * (V_ACTIVE >> SCALE_SH);
  localparam int AW = $clog2(FB_N);
  localparam int FW = PIX_BITS / 3;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [AW:0] FB_N_W = (AW + 1)'(FB_N);
  localparam logic SP = SYNC_POL[0];
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic active, hsync, vsync, sof;
  logic act1, hs1, vs1, sof1, fb1;
  mode_t mode_q, cur_mode;
  logic [2:0] bar_idx;
  logic [AW-1:0] rd_addr;
  logic [PIX_BITS-1:0] mem [FB_N];
  logic [PIX_BITS-1:0] rd_data;
  logic [23:0] pat0, pat1, fb_rgb;
  assign VGA_CLK = clk;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .active(active), .hsync(hsync), .vsync(vsync), .sof(sof)
  );
  // The incoming mode is taken at the very first pixel so the whole frame, pixel (0,0) included, uses it.
  always_comb begin
    cur_mode = sof ? mode_t'(sys.mode) : mode_q;
    bar_idx = 3'(h_cnt / HW'(BAR_W));
    pat0 = cur_mode == MODE_BARS ? BAR_RGB[bar_idx] :
           (cur_mode == MODE_CHECK && (h_cnt[5] ^ v_cnt[5])) ? 24'hFFFFFF : 24'h0;
    rd_addr = active ? AW'(32'(v_cnt >> SCALE_SH) * FB_W + 32'(h_cnt >> SCALE_SH)) : '0;
    fb_rgb = {expand(8'(rd_data[3*FW-1 -: FW]), FW),
              expand(8'(rd_data[2*FW-1 -: FW]), FW),
              expand(8'(rd_data[FW-1:0]), FW)};
  end
  // Read-first RAM: a same-cycle write to the address being read shows up only on the next read.
  always_ff @(posedge clk) begin
    if (sys.wr_en && {1'b0, sys.wr_addr} < FB_N_W) mem[sys.wr_addr] <= sys.wr_data;
    rd_data <= mem[rd_addr];
  end
  always_ff @(posedge clk)
    if (!rst) begin
      mode_q <= MODE_FB;
      act1 <= 1'b0;
      hs1 <= !SP;
      vs1 <= !SP;
      sof1 <= 1'b0;
      fb1 <= 1'b0;
      pat1 <= '0;
      VGA_BLANK_N <= 1'b0;
      VGA_HSYNC <= !SP;
      VGA_VSYNC <= !SP;
      frame_start <= 1'b0;
      {VGA_R, VGA_G, VGA_B} <= '0;
    end else begin
      mode_q <= cur_mode;
      act1 <= active;
      hs1 <= hsync;
      vs1 <= vsync;
      sof1 <= sof;
      fb1 <= cur_mode == MODE_FB;
      pat1 <= pat0;
      VGA_BLANK_N <= act1;
      VGA_HSYNC <= hs1;
      VGA_VSYNC <= vs1;
      frame_start <= sof1;
      {VGA_R, VGA_G, VGA_B} <= !act1 ? '0 : fb1 ? fb_rgb : pat1;
    end
endmodule

// File: tb/tb_vga_fb_disp.sv
// tb_vga_fb_disp: randomized self-checking bench for vga_fb_disp against a frame-level pixel model
module tb_vga_fb_disp;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int FBW = HA / 2;
  localparam int FBN = FBW * (VA / 2);
  localparam int AW = $clog2(FBN);

  logic clk = 0, rst = 0;
  always #5 clk = ~clk;

  vga_fb_disp_if #(.AW(AW), .PIX_BITS(12)) bus ();
  logic frame_start, vga_clk, hs, vs, bn;
  logic [7:0] r, g, b;
  logic [23:0] rgb;
  logic [27:0] got;
  assign rgb = {r, g, b};
  assign got = {bn, hs, vs, frame_start, rgb};

  vga_fb_disp #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .SCALE_SH(1), .PIX_BITS(12)
  ) dut (
    .clk(clk), .rst(rst), .sys(bus), .frame_start(frame_start), .VGA_CLK(vga_clk),
    .VGA_HSYNC(hs), .VGA_VSYNC(vs), .VGA_BLANK_N(bn), .VGA_R(r), .VGA_G(g), .VGA_B(b)
  );

  int t = 0, checks = 0, failures = 0;
  logic [11:0] fb_model [FBN];
  logic [1:0] frame_modes [16];
  logic h0_v = 0, h1_v = 0;
  int h0_a = 0, h1_a = 0;
  logic [11:0] h0_o = 0, h1_o = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // t = clock edges since reset release; the mode of each frame is what the bus held at its first edge.
  always @(posedge clk) begin
    if (rst) begin
      if (t % FT == 0) frame_modes[t / FT] <= bus.mode;
      t <= t + 1;
    end else t <= 0;
    h1_v <= h0_v;
    h1_a <= h0_a;
    h1_o <= h0_o;
    h0_v <= bus.wr_en && int'(bus.wr_addr) < FBN;
    h0_a <= int'(bus.wr_addr);
    h0_o <= fb_model[int'(bus.wr_addr) % FBN];
    if (bus.wr_en && int'(bus.wr_addr) < FBN) fb_model[bus.wr_addr] <= bus.wr_data;
  end

  function automatic logic [23:0] x12(input logic [11:0] p);
    return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
  endfunction

  // Pixel shown at time tt was fetched two edges earlier, so undo the two most recent writes.
  function automatic logic [11:0] fb_get(input int a);
    logic [11:0] v;
    v = fb_model[a];
    if (h0_v && h0_a == a) v = h0_o;
    if (h1_v && h1_a == a) v = h1_o;
    return v;
  endfunction

  function automatic logic [27:0] model_out(input int tt);
    int p, f, x, y, m;
    logic act;
    logic [23:0] c;
    if (tt < 2) return {1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    p = (tt - 2) % FT;
    f = (tt - 2) / FT;
    x = p % HT;
    y = p / HT;
    act = x < HA && y < VA;
    m = int'(frame_modes[f]);
    c = 24'h0;
    if (act) begin
      if (m == 0) c = x12(fb_get((y / 2) * FBW + x / 2));
      else if (m == 1) c = bars[x / 8];
      else if (m == 2) c = ((x / 32 + y / 32) % 2 == 1) ? 24'hFFFFFF : 24'h0;
    end
    return {act, !(x >= HA + HF && x < HA + HF + HS), !(y >= VA + VF && y < VA + VF + VS), p == 0, c};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [27:0] e;
    rst = 0;
    bus.wr_en = 0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.mode = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got !== 28'h6000000) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", got, 28'h6000000);
    end
    rst = 1;
    repeat (3) begin
      step;
      e = model_out(t);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_release t=%0d got=%h exp=%h", t, got, e);
      end
      if (t == 2) begin
        checks++;
        if (frame_start !== 1'b1 || bn !== 1'b1) begin
          failures++;
          $display("FAIL first_frame_start t=%0d fs=%b blank_n=%b exp 1/1", t, frame_start, bn);
        end
      end
    end
  endtask

  task automatic test_fill;
    logic [27:0] e;
    for (int a = 0; a < FBN; a++) begin
      bus.wr_en = 1;
      bus.wr_addr = AW'(a);
      bus.wr_data = 12'($urandom_range(0, 4095));
      step;
      e = model_out(t);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL fill_bars t=%0d got=%h exp=%h", t, got, e);
      end
    end
    bus.wr_en = 0;
  endtask

  task automatic test_timing;
    logic [27:0] e;
    logic phs = 1, pvs = 1;
    int hs_fall = -1, vs_fall = -1;
    bus.mode = 2'd2;
    while (t < 2 + FT + 10 * HT) begin
      step;
      e = model_out(t);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL timing_pixel t=%0d got=%h exp=%h", t, got, e);
      end
      if (phs && !hs) begin
        checks++;
        if ((t - 2) % HT != HA + HF || (hs_fall >= 0 && t - hs_fall != HT)) begin
          failures++;
          $display("FAIL hsync_start t=%0d col=%0d period=%0d exp col=%0d period=%0d", t, (t - 2) % HT, t - hs_fall, HA + HF, HT);
        end
        hs_fall = t;
      end
      if (!phs && hs && hs_fall >= 0) begin
        checks++;
        if (t - hs_fall != HS) begin
          failures++;
          $display("FAIL hsync_width got=%0d exp=%0d", t - hs_fall, HS);
        end
      end
      if (pvs && !vs) begin
        checks++;
        if ((t - 2) % FT != (VA + VF) * HT) begin
          failures++;
          $display("FAIL vsync_start got=%0d exp=%0d", (t - 2) % FT, (VA + VF) * HT);
        end
        vs_fall = t;
      end
      if (!pvs && vs && vs_fall >= 0) begin
        checks++;
        if (t - vs_fall != VS * HT) begin
          failures++;
          $display("FAIL vsync_width got=%0d exp=%0d", t - vs_fall, VS * HT);
        end
      end
      if (frame_start === 1'b1) begin
        checks++;
        if ((t - 2) % FT != 0) begin
          failures++;
          $display("FAIL frame_start_period t=%0d offset=%0d exp 0", t, (t - 2) % FT);
        end
      end
      phs = hs;
      pvs = vs;
    end
  endtask

  task automatic test_mode_switch;
    logic [27:0] e;
    bus.mode = 2'd0;
    while (t < 2 + 2 * FT - 2 * HT) begin
      step;
      e = model_out(t);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL mode_switch t=%0d got=%h exp=%h", t, got, e);
      end
      if (t == 2 + FT + 20 * HT + 40) begin
        checks++;
        if (rgb !== 24'hFFFFFF) begin
          failures++;
          $display("FAIL no_tearing got=%h exp=%h", rgb, 24'hFFFFFF);
        end
      end
    end
  endtask

  task automatic test_pixels;
    logic [27:0] e;
    logic [23:0] c;
    int q;
    bus.wr_en = 1;
    bus.wr_addr = AW'(0);
    bus.wr_data = 12'hF80;
    step;
    bus.wr_addr = AW'(1);
    bus.wr_data = 12'h00F;
    step;
    bus.wr_en = 0;
    while (t < 2 + 2 * FT + 2 * HT) begin
      step;
      e = model_out(t);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL fb_pixel t=%0d got=%h exp=%h", t, got, e);
      end
      q = t - (2 + 2 * FT);
      if (q >= 0 && q / HT < 2 && q % HT < 4) begin
        c = (q % HT) < 2 ? 24'hFF8800 : 24'h0000FF;
        checks++;
        if (rgb !== c) begin
          failures++;
          $display("FAIL fb_expand x=%0d y=%0d got=%h exp=%h", q % HT, q / HT, rgb, c);
        end
      end
    end
  endtask

  task automatic test_oob;
    logic [27:0] e;
    bus.wr_en = 1;
    bus.wr_addr = AW'(FBN);
    bus.wr_data = 12'hABC;
    step;
    bus.wr_addr = '1;
    bus.wr_data = 12'h123;
    step;
    bus.wr_en = 0;
    while (t < 2 + 3 * FT + VA * HT) begin
      step;
      e = model_out(t);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL oob_readback t=%0d got=%h exp=%h", t, got, e);
      end
    end
  endtask

  task automatic test_collision;
    logic [27:0] e;
    logic [11:0] old_v, new_v;
    int base;
    base = 2 + 4 * FT;
    old_v = 0;
    new_v = 0;
    while (t < base + 2 * HT) begin
      if (t == 4 * FT + 11) begin
        old_v = fb_model[5];
        new_v = old_v ^ 12'hFFF;
        bus.wr_en = 1;
        bus.wr_addr = AW'(5);
        bus.wr_data = new_v;
      end else bus.wr_en = 0;
      step;
      e = model_out(t);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL collision_pixel t=%0d got=%h exp=%h", t, got, e);
      end
      if (t == base + 10 || t == base + 11) begin
        checks++;
        if (rgb !== x12(old_v)) begin
          failures++;
          $display("FAIL read_first_old t=%0d got=%h exp=%h", t, rgb, x12(old_v));
        end
      end
      if (t == base + HT + 10 || t == base + HT + 11) begin
        checks++;
        if (rgb !== x12(new_v)) begin
          failures++;
          $display("FAIL read_first_new t=%0d got=%h exp=%h", t, rgb, x12(new_v));
        end
      end
    end
    bus.wr_en = 0;
  endtask

  task automatic test_bar_switch;
    logic [27:0] e;
    logic [23:0] c;
    int q;
    while (t < 2 + 5 * FT + 2 * HT) begin
      if (t == 2 + 4 * FT + 20 * HT) bus.mode = 2'd1;
      step;
      e = model_out(t);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL bar_switch t=%0d got=%h exp=%h", t, got, e);
      end
      q = t - (2 + 5 * FT);
      if (q == 0 || q == 8 || q == 16 || q == 56 || q == 63) begin
        c = q == 0 ? 24'hFFFFFF : q == 8 ? 24'hFFFF00 : q == 16 ? 24'h00FFFF : 24'h000000;
        checks++;
        if (rgb !== c) begin
          failures++;
          $display("FAIL bar_colour x=%0d got=%h exp=%h", q, rgb, c);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_timing;
    test_mode_switch;
    test_pixels;
    test_oob;
    test_collision;
    test_bar_switch;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
